// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee machine controller and its display block.
package coffee_pkg;

  // Machine state codes; the display block decodes exactly these values.
  typedef enum logic [2:0] {
    WAITING        = 3'd0,
    SELECTION      = 3'd1,
    PAYMENT        = 3'd2,
    IMPLEMENTATION = 3'd3,
    UNSUCCESSFUL   = 3'd4
  } state_t;

  // The single button command acted on in a given cycle after priority resolution.
  typedef enum logic [2:0] {
    CMD_NONE      = 3'd0,
    CMD_WAITING   = 3'd1,
    CMD_SELECTION = 3'd2,
    CMD_LEFT      = 3'd3,
    CMD_RIGHT     = 3'd4
  } cmd_t;

  // Drink prices indexed by selection_drink.
  localparam logic [7:0] PRICE [4] = '{8'd15, 8'd20, 8'd25, 8'd30};

  localparam logic [7:0] MONEY_MAX   = 8'd99;
  localparam logic [7:0] PROCENT_MAX = 8'd100;

  // Resolves simultaneous press events: Waiting > Selection > Left > Right.
  function automatic cmd_t pick_command(input logic w, input logic s,
                                        input logic l, input logic r);
    cmd_t c;
    if (w)      c = CMD_WAITING;
    else if (s) c = CMD_SELECTION;
    else if (l) c = CMD_LEFT;
    else if (r) c = CMD_RIGHT;
    else        c = CMD_NONE;
    return c;
  endfunction

  // Adds one coin to the credit, saturating at the two-digit display limit.
  function automatic logic [7:0] add_coin(input logic [7:0] m, input logic [7:0] coin);
    logic [8:0] sum;
    sum = {1'b0, m} + {1'b0, coin};
    if (sum > {1'b0, MONEY_MAX}) return MONEY_MAX;
    return sum[7:0];
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronizes and debounces one raw active-low button and emits a one-cycle press pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_raw,
  output logic press_pulse
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_q1;
  logic          sync_q2;
  logic          stable_q;
  logic          stable_d1;
  logic [CW-1:0] cnt_q;

  // Two-flop synchronizer; idle level is high (released).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= btn_n_raw;
      sync_q2 <= sync_q1;
    end
  end

  // Accept a new level only after it has differed from the stable level for the full window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_q <= 1'b1;
      cnt_q    <= '0;
    end else if (sync_q2 == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      stable_q <= sync_q2;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Registered falling-edge detect on the debounced level gives the press pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_d1   <= 1'b1;
      press_pulse <= 1'b0;
    end else begin
      stable_d1   <= stable_q;
      press_pulse <= stable_d1 & ~stable_q;
    end
  end

endmodule

// File: rtl/coffee_machine_ctrl.sv
// Coffee machine sequencing controller: button conditioning plus the machine FSM.
module coffee_machine_ctrl
  import coffee_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = 1_000_000,
  parameter int STEP_CYCLES         = 5_000_000,
  parameter int IDLE_TIMEOUT_CYCLES = 500_000_000,
  parameter int HOLD_CYCLES         = 100_000_000,
  parameter int COIN_VALUE          = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       buttonWaiting,
  input  logic       buttonLeft,
  input  logic       buttonRight,
  input  logic       buttonSelection,
  output logic [2:0] state,
  output logic [1:0] selection_drink,
  output logic [7:0] money,
  output logic [7:0] procent,
  output logic       brew_on,
  output logic       refund_valid,
  output logic [7:0] refund_amount
);

  localparam int MAX_A   = (STEP_CYCLES > IDLE_TIMEOUT_CYCLES) ? STEP_CYCLES : IDLE_TIMEOUT_CYCLES;
  localparam int MAX_CYC = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] IDLE_LAST = CW'(IDLE_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [7:0]    COIN      = 8'(COIN_VALUE);

  logic          press_w;
  logic          press_s;
  logic          press_l;
  logic          press_r;
  cmd_t          cmd;
  state_t        state_q;
  logic [CW-1:0] idle_cnt;
  logic [CW-1:0] step_cnt;
  logic [CW-1:0] hold_cnt;
  logic [7:0]    price_now;
  logic          idle_expired;
  logic          pay_abort;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_waiting (
    .clk(clk), .rst_n(rst_n), .btn_n_raw(buttonWaiting), .press_pulse(press_w)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_selection (
    .clk(clk), .rst_n(rst_n), .btn_n_raw(buttonSelection), .press_pulse(press_s)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk(clk), .rst_n(rst_n), .btn_n_raw(buttonLeft), .press_pulse(press_l)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk(clk), .rst_n(rst_n), .btn_n_raw(buttonRight), .press_pulse(press_r)
  );

  // Priority-resolved command, current price and the Payment give-up condition.
  always_comb begin
    cmd          = pick_command(press_w, press_s, press_l, press_r);
    price_now    = PRICE[selection_drink];
    idle_expired = (idle_cnt == IDLE_LAST);
    pay_abort    = ((cmd == CMD_SELECTION) && (money < price_now)) ||
                   (cmd == CMD_LEFT) || (cmd == CMD_WAITING) ||
                   ((cmd == CMD_NONE) && idle_expired);
  end

  assign state = state_q;

  // Machine FSM with all outputs and counters registered in one place.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= WAITING;
      selection_drink <= 2'd0;
      money           <= 8'd0;
      procent         <= 8'd0;
      brew_on         <= 1'b0;
      refund_valid    <= 1'b0;
      refund_amount   <= 8'd0;
      idle_cnt        <= '0;
      step_cnt        <= '0;
      hold_cnt        <= '0;
    end else begin
      refund_valid <= 1'b0;
      case (state_q)
        WAITING: begin
          idle_cnt <= '0;
          step_cnt <= '0;
          hold_cnt <= '0;
          brew_on  <= 1'b0;
          procent  <= 8'd0;
          if (cmd == CMD_WAITING) begin
            state_q         <= SELECTION;
            selection_drink <= 2'd0;
            money           <= 8'd0;
          end
        end

        SELECTION: begin
          case (cmd)
            CMD_WAITING: begin
              state_q  <= WAITING;
              idle_cnt <= '0;
            end
            CMD_SELECTION: begin
              state_q  <= PAYMENT;
              money    <= 8'd0;
              idle_cnt <= '0;
            end
            CMD_LEFT: begin
              selection_drink <= selection_drink - 2'd1;
              idle_cnt        <= '0;
            end
            CMD_RIGHT: begin
              selection_drink <= selection_drink + 2'd1;
              idle_cnt        <= '0;
            end
            default: begin
              if (idle_expired) begin
                state_q  <= WAITING;
                idle_cnt <= '0;
              end else begin
                idle_cnt <= idle_cnt + 1'b1;
              end
            end
          endcase
        end

        PAYMENT: begin
          if (pay_abort) begin
            state_q  <= UNSUCCESSFUL;
            hold_cnt <= '0;
            idle_cnt <= '0;
            money    <= 8'd0;
            if (money != 8'd0) begin
              refund_valid  <= 1'b1;
              refund_amount <= money;
            end
          end else if (cmd == CMD_SELECTION) begin
            state_q  <= IMPLEMENTATION;
            procent  <= 8'd0;
            step_cnt <= '0;
            hold_cnt <= '0;
            idle_cnt <= '0;
            brew_on  <= 1'b1;
            if (money > price_now) begin
              refund_valid  <= 1'b1;
              refund_amount <= money - price_now;
            end
          end else if (cmd == CMD_RIGHT) begin
            money    <= add_coin(money, COIN);
            idle_cnt <= '0;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end

        IMPLEMENTATION: begin
          idle_cnt <= '0;
          if (procent < PROCENT_MAX) begin
            if (step_cnt == STEP_LAST) begin
              step_cnt <= '0;
              procent  <= procent + 8'd1;
              hold_cnt <= '0;
              if (procent == PROCENT_MAX - 8'd1) begin
                brew_on <= 1'b0;
              end
            end else begin
              step_cnt <= step_cnt + 1'b1;
            end
          end else if (hold_cnt == HOLD_LAST) begin
            state_q  <= WAITING;
            procent  <= 8'd0;
            money    <= 8'd0;
            hold_cnt <= '0;
            brew_on  <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        UNSUCCESSFUL: begin
          idle_cnt <= '0;
          brew_on  <= 1'b0;
          if (hold_cnt == HOLD_LAST) begin
            state_q  <= WAITING;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: begin
          state_q  <= WAITING;
          brew_on  <= 1'b0;
          idle_cnt <= '0;
          step_cnt <= '0;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coffee_machine_ctrl.sv
// Scoreboard testbench for coffee_machine_ctrl with a behavioural reference model.
module tb_coffee_machine_ctrl;

  localparam int DEB  = 4;
  localparam int STEP = 3;
  localparam int HOLD = 10;
  localparam int IDLE = 50;
  localparam int COIN = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       buttonWaiting = 1'b1;
  logic       buttonLeft = 1'b1;
  logic       buttonRight = 1'b1;
  logic       buttonSelection = 1'b1;
  logic [2:0] state;
  logic [1:0] selection_drink;
  logic [7:0] money;
  logic [7:0] procent;
  logic       brew_on;
  logic       refund_valid;
  logic [7:0] refund_amount;

  coffee_machine_ctrl #(
    .DEBOUNCE_CYCLES(DEB), .STEP_CYCLES(STEP), .IDLE_TIMEOUT_CYCLES(IDLE),
    .HOLD_CYCLES(HOLD), .COIN_VALUE(COIN)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .buttonWaiting(buttonWaiting), .buttonLeft(buttonLeft),
    .buttonRight(buttonRight), .buttonSelection(buttonSelection),
    .state(state), .selection_drink(selection_drink), .money(money),
    .procent(procent), .brew_on(brew_on), .refund_valid(refund_valid),
    .refund_amount(refund_amount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] sel;
    logic [7:0] money;
    logic [7:0] procent;
    logic       rv;
    logic [7:0] ra;
  } exp_t;

  exp_t expQ[$];
  int   cmpCount = 0;
  int   failCount = 0;
  int   eventCount = 0;
  bit   monitorOn = 1'b0;

  int mState = 0;
  int mSel = 0;
  int mMoney = 0;

  // Mask bits: [3] Waiting, [2] Selection, [1] Left, [0] Right.
  localparam logic [3:0] B_W = 4'b1000;
  localparam logic [3:0] B_S = 4'b0100;
  localparam logic [3:0] B_L = 4'b0010;
  localparam logic [3:0] B_R = 4'b0001;

  task automatic checkOutput(input string name, input int actual, input int expected);
    cmpCount++;
    if (actual != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic int priceOf(input int d);
    return 15 + 5 * d;
  endfunction

  task automatic pushExp(input int st, input int sel, input int m, input int rv, input int ra);
    exp_t e;
    e.st = 3'(st); e.sel = 2'(sel); e.money = 8'(m); e.procent = 8'd0;
    e.rv = rv[0]; e.ra = 8'(ra);
    expQ.push_back(e);
  endtask

  // Failed or abandoned payment: refund whatever was paid, show Unsuccessful, then return home.
  task automatic modelAbort();
    pushExp(4, mSel, 0, (mMoney > 0) ? 1 : 0, mMoney);
    pushExp(0, mSel, 0, 0, 0);
    mMoney = 0;
    mState = 0;
  endtask

  // kind: 0 no long-running follow-up, 1 brew started, 2 Unsuccessful hold started.
  task automatic modelPress(input logic [3:0] mask, output int kind);
    int btn;
    int nm;
    kind = 0;
    btn = mask[3] ? 3 : mask[2] ? 2 : mask[1] ? 1 : mask[0] ? 0 : -1;
    case (mState)
      0: if (btn == 3) begin
           mState = 1; mSel = 0; mMoney = 0;
           pushExp(1, 0, 0, 0, 0);
         end
      1: case (btn)
           3: begin mState = 0; pushExp(0, mSel, 0, 0, 0); end
           2: begin mState = 2; mMoney = 0; pushExp(2, mSel, 0, 0, 0); end
           1: begin mSel = (mSel + 3) % 4; pushExp(1, mSel, 0, 0, 0); end
           0: begin mSel = (mSel + 1) % 4; pushExp(1, mSel, 0, 0, 0); end
           default: ;
         endcase
      2: case (btn)
           0: begin
             nm = (mMoney + COIN > 99) ? 99 : mMoney + COIN;
             if (nm != mMoney) pushExp(2, mSel, nm, 0, 0);
             mMoney = nm;
           end
           2: begin
             if (mMoney >= priceOf(mSel)) begin
               pushExp(3, mSel, mMoney, (mMoney > priceOf(mSel)) ? 1 : 0, mMoney - priceOf(mSel));
               pushExp(0, mSel, 0, 0, 0);
               mMoney = 0; mState = 0; kind = 1;
             end else begin
               modelAbort(); kind = 2;
             end
           end
           1, 3: begin modelAbort(); kind = 2; end
           default: ;
         endcase
      default: ;
    endcase
  endtask

  task automatic modelTimeout();
    if (mState == 1) begin
      mState = 0;
      pushExp(0, mSel, 0, 0, 0);
    end else if (mState == 2) begin
      modelAbort();
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] mask);
    buttonWaiting   = ~mask[3];
    buttonSelection = ~mask[2];
    buttonLeft      = ~mask[1];
    buttonRight     = ~mask[0];
    waitCycles(10);
    buttonWaiting = 1'b1; buttonSelection = 1'b1; buttonLeft = 1'b1; buttonRight = 1'b1;
    waitCycles(10);
  endtask

  task automatic doPress(input logic [3:0] mask, input bit pokeDuringBrew);
    int kind;
    modelPress(mask, kind);
    applyStimulus(mask);
    if (kind == 1) begin
      if (pokeDuringBrew) begin
        applyStimulus(4'($urandom_range(1, 15)));
        waitCycles(300);
      end else begin
        waitCycles(320);
      end
    end else if (kind == 2) begin
      waitCycles(5);
    end
  endtask

  // Monitor state: previous sampled outputs and timing marks for brew/hold checks.
  logic [2:0] prevSt;
  logic [1:0] prevSel;
  logic [7:0] prevMoney;
  logic       prevRv;
  exp_t       monExp;
  int         cyc = 0;
  int         implStart = 0;
  int         hundredAt = -1;
  int         unsStart = 0;
  bit         brewOk = 1'b1;
  bit         match;

  always @(negedge clk) begin
    if (monitorOn) begin
      cyc++;
      if (state != prevSt || selection_drink != prevSel || money != prevMoney || refund_valid) begin
        eventCount++;
        cmpCount++;
        if (expQ.size() == 0) begin
          failCount++;
          $display("[TB] FAIL unexpected_event: got st=%0d sel=%0d money=%0d rv=%0d ra=%0d, required no event",
                   state, selection_drink, money, refund_valid, refund_amount);
        end else begin
          monExp = expQ.pop_front();
          match = (state == monExp.st) && (selection_drink == monExp.sel) &&
                  (money == monExp.money) && (procent == monExp.procent) &&
                  (refund_valid == monExp.rv) && (!monExp.rv || refund_amount == monExp.ra);
          if (!match) begin
            failCount++;
            $display("[TB] FAIL event_%0d: got st=%0d sel=%0d money=%0d procent=%0d rv=%0d ra=%0d, expected st=%0d sel=%0d money=%0d procent=%0d rv=%0d ra=%0d",
                     eventCount, state, selection_drink, money, procent, refund_valid, refund_amount,
                     monExp.st, monExp.sel, monExp.money, monExp.procent, monExp.rv, monExp.ra);
          end
        end
      end
      if (refund_valid) checkOutput("refund_single_cycle", int'(prevRv), 0);
      if (prevSt != 3'd3 && state == 3'd3) begin
        implStart = cyc; hundredAt = -1; brewOk = 1'b1;
      end
      if (state == 3'd3 && procent < 8'd100 && !brew_on) brewOk = 1'b0;
      if (state == 3'd3 && procent == 8'd100 && hundredAt < 0) begin
        hundredAt = cyc;
        checkOutput("brew_duration", cyc - implStart, 100 * STEP);
        checkOutput("brew_off_at_100", int'(brew_on), 0);
      end
      if (prevSt == 3'd3 && state != 3'd3 && hundredAt >= 0) begin
        checkOutput("brew_hold", cyc - hundredAt, HOLD);
        checkOutput("brew_on_while_brewing", int'(brewOk), 1);
        hundredAt = -1;
      end
      if (prevSt != 3'd4 && state == 3'd4) unsStart = cyc;
      if (prevSt == 3'd4 && state != 3'd4) checkOutput("unsuccessful_hold", cyc - unsStart, HOLD);
      prevSt = state; prevSel = selection_drink; prevMoney = money; prevRv = refund_valid;
    end
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int lat;
    int evBefore;
    int kind;
    logic [3:0] mask;
    int r;

    // Reset state.
    waitCycles(3);
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_sel", int'(selection_drink), 0);
    checkOutput("reset_money", int'(money), 0);
    checkOutput("reset_procent", int'(procent), 0);
    checkOutput("reset_brew_on", int'(brew_on), 0);
    checkOutput("reset_refund_valid", int'(refund_valid), 0);
    checkOutput("reset_refund_amount", int'(refund_amount), 0);
    rst_n = 1'b1;
    prevSt = 3'd0; prevSel = 2'd0; prevMoney = 8'd0; prevRv = 1'b0;
    monitorOn = 1'b1;
    waitCycles(2);

    // Press latency: debounce path plus one cycle for the state register.
    modelPress(B_W, kind);
    buttonWaiting = 1'b0;
    lat = 0;
    while (lat < 30 && state != 3'd1) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("press_latency", lat, DEB + 4);
    waitCycles(2);
    buttonWaiting = 1'b1;
    waitCycles(10);

    // Bounce on Right: only the final stable low counts.
    evBefore = eventCount;
    modelPress(B_R, kind);
    for (int i = 0; i < 6; i++) begin
      buttonRight = i[0];
      waitCycles(2);
    end
    buttonRight = 1'b0;
    waitCycles(10);
    buttonRight = 1'b1;
    waitCycles(10);
    checkOutput("bounce_event_count", eventCount - evBefore, 1);

    // Wrap-around of the drink index.
    doPress(B_L, 1'b0);
    doPress(B_L, 1'b0);
    doPress(B_R, 1'b0);

    // Exact payment for drink 1.
    doPress(B_R, 1'b0);
    doPress(B_S, 1'b0);
    repeat (4) doPress(B_R, 1'b0);
    doPress(B_S, 1'b0);

    // Overpay with saturation on drink 0.
    doPress(B_W, 1'b0);
    doPress(B_S, 1'b0);
    repeat (21) doPress(B_R, 1'b0);
    doPress(B_S, 1'b0);

    // Underpay on drink 3.
    doPress(B_W, 1'b0);
    doPress(B_L, 1'b0);
    doPress(B_S, 1'b0);
    repeat (2) doPress(B_R, 1'b0);
    doPress(B_S, 1'b0);

    // Simultaneous Left+Right in Payment: Left wins, coin is discarded.
    doPress(B_W, 1'b0);
    doPress(B_S, 1'b0);
    repeat (2) doPress(B_R, 1'b0);
    doPress(B_L | B_R, 1'b0);

    // Randomized sessions.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 99);
      case (mState)
        0: mask = (r < 70) ? B_W : 4'(1 << $urandom_range(0, 2));
        1: mask = (r < 35) ? B_L : (r < 70) ? B_R : (r < 92) ? B_S : B_W;
        default: mask = (r < 60) ? B_R : (r < 80) ? B_S : (r < 90) ? B_L : B_W;
      endcase
      if ($urandom_range(0, 9) == 0) mask = mask | 4'(1 << $urandom_range(0, 3));
      doPress(mask, $urandom_range(0, 1) == 1);
    end
    if (mState != 0) begin
      modelTimeout();
      waitCycles(90);
    end

    // Idle timeouts in Selection and in Payment.
    doPress(B_W, 1'b0);
    modelTimeout();
    waitCycles(70);
    doPress(B_W, 1'b0);
    doPress(B_S, 1'b0);
    doPress(B_R, 1'b0);
    modelTimeout();
    waitCycles(80);

    // Reset in the middle of a brew: everything clears, no refund.
    doPress(B_W, 1'b0);
    doPress(B_S, 1'b0);
    repeat (4) doPress(B_R, 1'b0);
    modelPress(B_S, kind);
    applyStimulus(B_S);
    waitCycles(30);
    if (expQ.size() > 0) void'(expQ.pop_back());
    pushExp(0, 0, 0, 0, 0);
    mState = 0; mSel = 0; mMoney = 0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkOutput("midreset_state", int'(state), 0);
    checkOutput("midreset_sel", int'(selection_drink), 0);
    checkOutput("midreset_money", int'(money), 0);
    checkOutput("midreset_procent", int'(procent), 0);
    checkOutput("midreset_brew_on", int'(brew_on), 0);
    checkOutput("midreset_refund_valid", int'(refund_valid), 0);
    checkOutput("midreset_refund_amount", int'(refund_amount), 0);
    rst_n = 1'b1;
    waitCycles(20);

    checkOutput("scoreboard_drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, failCount);
    $finish;
  end

endmodule

// File: doc/coffee_machine_ctrl.md
Name: coffee_machine_ctrl

Overview:
- Sequencing controller for the coffee-machine demo: debounces the four front-panel buttons and runs the machine FSM (Waiting, Selection, Payment, Implementation, Unsuccessful).
- Produces the state code, drink index, credited money and brew percent consumed by the existing LED/7-segment display block.
- Also drives the brew actuator and reports refunds/change.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, cycles a raw button level must stay stable before it is accepted (20 ms at 50 MHz).
- STEP_CYCLES, 5_000_000, cycles per +1 % of brew progress.
- IDLE_TIMEOUT_CYCLES, 500_000_000, cycles without an accepted press before Selection/Payment is abandoned.
- HOLD_CYCLES, 100_000_000, cycles the Unsuccessful state and the 100 % reading are held.
- COIN_VALUE, 5, money added per coin press.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst_n  in  1  synchronous active-low reset.
- buttonWaiting  in  1  raw, active-low: start/abort.
- buttonLeft  in  1  raw, active-low: previous drink / cancel payment.
- buttonRight  in  1  raw, active-low: next drink / insert coin.
- buttonSelection  in  1  raw, active-low: confirm.
- state  out  3  0 Waiting, 1 Selection, 2 Payment, 3 Implementation, 4 Unsuccessful.
- selection_drink  out  2  current drink index 0..3.
- money  out  8  credited amount, 0..99.
- procent  out  8  brew progress, 0..100.
- brew_on  out  1  high only while in Implementation with procent < 100.
- refund_valid  out  1  one-cycle pulse.
- refund_amount  out  8  value qualified by refund_valid.

Behaviour:
- Reset: rst_n sampled on the clk edge only; it is synchronous and active-low. Any cycle with rst_n=0 forces state=0, selection_drink=0, money=0, procent=0, brew_on=0, refund_valid=0, refund_amount=0, and clears all counters. This applies mid-brew too: no refund is issued.
- Button input path:
  - Each button goes through a 2-FF synchronizer, then a debounce counter.
  - A press event is a one-cycle pulse on the debounced 1→0 transition.
  - Latency from a stable raw low to the event is DEBOUNCE_CYCLES+3 cycles.
- Simultaneous press events in one cycle: only the highest-priority one is acted on. Priority is Waiting > Selection > Left > Right; the others are discarded.
- Idle counter: cleared on every state change and on every accepted press.
- Waiting:
  - Waiting press → Selection, selection_drink=0, money=0.
  - All other presses are ignored.
- Selection:
  - Left: selection_drink -1, with 0 wrapping to 3.
  - Right: selection_drink +1, with 3 wrapping to 0.
  - Selection press → Payment, money=0.
  - Waiting press, or idle counter reaching IDLE_TIMEOUT_CYCLES → Waiting.
- Payment:
  - Right: money += COIN_VALUE, saturating at 99.
  - Selection press, money ≥ PRICE[sel] → Implementation, procent=0, step counter=0. If money > price, pulse refund_valid with refund_amount = money − price.
  - Selection press, money < price → Unsuccessful.
  - Left press, Waiting press, or idle timeout → Unsuccessful.
  - On every exit to Unsuccessful with money > 0: refund_valid pulses with refund_amount = money, in the same cycle the state changes. money then clears to 0.
- Implementation:
  - Buttons are ignored, including Waiting.
  - Step counter counts to STEP_CYCLES−1, then procent +1.
  - At procent=100: brew_on drops in that same cycle, and the value is held HOLD_CYCLES cycles, then → Waiting with procent=0, money=0.
- Unsuccessful: buttons ignored; after HOLD_CYCLES cycles → Waiting.
- All outputs are registered. The state output changes 1 cycle after the triggering press pulse.
- Widths: money and procent are 8-bit unsigned; the change subtraction is done only when money ≥ price, so it never underflows. Counters are sized by $clog2 of the largest parameter.
- Undefined state codes 5–7 → Waiting on the next cycle.

Decomposition:
- Shared package coffee_pkg:
  - State constants WAITING=0 … UNSUCCESSFUL=4, matching the display block's encoding.
  - PRICE array {15, 20, 25, 30} indexed by drink.
  - MONEY_MAX=99 and PROCENT_MAX=100.
- One sub-module, button_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, btn_n_raw, press_pulse). It is instantiated four times.

Test Plan:
- Run with DEBOUNCE_CYCLES=4, STEP_CYCLES=3, HOLD_CYCLES=10, IDLE_TIMEOUT_CYCLES=50.
- Bounce: toggle buttonRight every 2 cycles, then hold it low 10 cycles → exactly one press event; selection_drink 0→1, with no event during the bounce.
- Wrap: in Selection at 0, press Left → 3; press Right → 0.
- Exact payment: drink 1 (price 20), 4 coins → money=20; Selection → state=3, refund_valid stays 0. procent reaches 100 after 300 cycles with brew_on=1 throughout, then brew_on=0; state=0 after 10 more cycles.
- Overpay/saturation: drink 0, 21 coins → money=99; Selection → refund_valid pulse with refund_amount=84, state=3.
- Underpay: drink 3, 2 coins → money=10; Selection → state=4 with a refund pulse of 10; state=0 after 10 cycles.
- Simultaneous presses and reset: in Payment, Left+Right in the same cycle → Unsuccessful, money unchanged before the refund. Assert rst_n=0 for 1 cycle during Implementation → all outputs 0 on the next edge, with no refund pulse.
